// File: rtl/serial_addsub_seq.sv
// -----------------------------------------------------------------------------
// serial_addsub_seq
//   Bit-serial add/subtract sequencer. It drives one shared, purely
//   combinational 1-bit full-adder cell and produces a WIDTH-bit result,
//   LSB first, one bit per clock.
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     start      request, sampled only while idle
//     op         0 = add, 1 = subtract (a_in - b_in), latched with start
//     a_in,b_in  operands, latched with start
//     busy       high while running and during the done cycle
//     done       one-cycle pulse, result/cout/ovf valid
//     result     sum/difference, held until the next accepted start
//     cout       final carry (subtract: 1 = no borrow)
//     ovf        signed two's-complement overflow
//     cell_a/b/cin  drive the shared full-adder cell
//     cell_s/cout   combinational outputs of the shared cell
// -----------------------------------------------------------------------------
module serial_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_cin,
    input  logic             cell_s,
    input  logic             cell_cout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_sop;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_run;

    assign w_run = (r_state == S_RUN);

    // Cell inputs come only from registers, so there is no combinational
    // loop through the shared cell. Subtract inverts B and relies on the
    // carry having been preset to 1 (a + ~b + 1).
    assign cell_a   = w_run & r_sa[0];
    assign cell_b   = w_run & (r_sb[0] ^ r_sop);
    assign cell_cin = w_run & r_carry;

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sop    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa    <= a_in;
                        r_sb    <= b_in;
                        r_sop   <= op;
                        r_carry <= op;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Sum bits enter at the MSB; after WIDTH shifts the
                    // first (LSB) bit has reached bit 0.
                    r_result <= {cell_s, r_result[WIDTH-1:1]};
                    r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
                    r_carry  <= cell_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_cout  <= cell_cout;
                        // carry into MSB xor carry out of MSB
                        r_ovf   <= r_carry ^ cell_cout;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
